med_ctrl: RTL
=============

MED_CTRL -- requirements
Module: med_ctrl

Interface
REQ-001 Parameter N_PIXELS, default 9, meaning pixels per median window; SHALL be odd and >= 3.
REQ-002 Port CLK  input  1  single clock; all state SHALL update on rising CLK.
REQ-003 Port nRST  input  1  reset, asynchronous and active-low.
REQ-004 Port DSI  input  1  upstream data strobe, high while the N_PIXELS window pixels are presented.
REQ-005 Port MED_DSI  output  1  load/shift strobe to the MED datapath.
REQ-006 Port BYP  output  1  compare-bypass select to the MED datapath.
REQ-007 Port DSO  output  1  one-cycle strobe: median valid on MED DO.
REQ-008 Port BUSY  output  1  high while a sort sequence runs; upstream DSI is ignored.
REQ-009 Port ERR  output  1  one-cycle pulse: load length differed from N_PIXELS.

Function
REQ-010 States SHALL be IDLE, LOAD, CMP, BYPS, FINAL, DONE.
REQ-011 IDLE/LOAD: MED_DSI SHALL equal DSI combinationally, BYP=0, BUSY=0.
REQ-012 IDLE -> LOAD on a rising edge with DSI=1; load counter cleared, then incremented on every edge with DSI=1 (first such edge counts 1), saturating at N_PIXELS+1.
REQ-013 LOAD -> CMP on the first edge with DSI=0 (edge E0) if count == N_PIXELS; else -> IDLE with ERR=1 for the following cycle.
REQ-014 Pass index i SHALL start at N_PIXELS-1 and run down to (N_PIXELS+1)/2, giving (N_PIXELS-1)/2 passes.
REQ-015 CMP: MED_DSI=0, BYP=0 for exactly i cycles; then BYPS.
REQ-016 BYPS: MED_DSI=1, BYP=1 for exactly N_PIXELS-i cycles; then i decrements and FSM -> CMP, or -> FINAL after the last pass.
REQ-017 FINAL: MED_DSI=0, BYP=0 for exactly (N_PIXELS-1)/2+1 cycles; then DONE.
REQ-018 DONE: DSO=1 for exactly one cycle, MED_DSI=0, BYP=0; then IDLE.
REQ-019 BUSY SHALL be 1 in CMP, BYPS, FINAL, DONE.
REQ-020 Outputs in CMP..DONE SHALL be registered (glitch-free); for N_PIXELS=9, the first CMP cycle begins at E0, DSO is high in the cycle starting at E0+41, and BUSY falls at E0+42.
REQ-021 DSI activity while BUSY=1 SHALL be ignored: no state change, no count, no effect on MED_DSI.
REQ-022 DSI high on the DONE->IDLE edge SHALL NOT start a load; a new load requires DSI sampled high in IDLE.
REQ-023 Counters SHALL be sized $clog2(N_PIXELS+2) bits; no wrap-around is reachable.

Reset
REQ-024 nRST low SHALL immediately force state IDLE, counters 0, BYP=0, DSO=0, BUSY=0, ERR=0; MED_DSI follows DSI per REQ-011.
REQ-025 Reset asserted mid-sequence SHALL abort it with no DSO pulse; operation resumes at the first rising edge after release.

Structure
REQ-026 Package med_pkg SHALL hold the state enum type and helper constants (pass count, final-phase length) as functions of N_PIXELS.
REQ-027 med_ctrl SHALL be a single module with no sub-module; the parent instantiates med_ctrl beside MED and connects MED_DSI/BYP.

Verification
REQ-028 N=9, DSI high 9 cycles then low -> BYP pattern per pass 8x0/1x1, 7x0/2x1, 6x0/3x1, 5x0/4x1, then 5x0, DSO one cycle at E0+41.
REQ-029 Pixels 9,3,7,1,5,8,2,6,4 through med_ctrl+MED -> DO=5 when DSO=1.
REQ-030 DSI high 8 cycles, and separately 10 cycles -> ERR pulse one cycle, no DSO, BUSY stays 0.
REQ-031 DSI toggled during BUSY -> sequence timing and DSO unchanged vs REQ-028.
REQ-032 nRST pulsed low at E0+20 -> all outputs 0 immediately, no DSO; next 9-pixel load completes normally.
REQ-033 N_PIXELS=3, pixels 7,2,4 -> BYP 2x0/1x1, 2x0, DSO at E0+5, DO=4.

Source files
------------

// File: rtl/med_pkg.sv
// rtl/med_pkg.sv - shared state type and window-size helpers for the median sort controller.
package med_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CMP,
    ST_BYPS,
    ST_FINAL,
    ST_DONE
  } med_state_t;

  function automatic int pass_count(input int n);
    return (n - 1) / 2;
  endfunction

  // Lowest pass index; passes run from n-1 down to this value inclusive.
  function automatic int last_idx(input int n);
    return n - pass_count(n);
  endfunction

  function automatic int final_len(input int n);
    return pass_count(n) + 1;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/med_ctrl.sv
// rtl/med_ctrl.sv - sequencer that loads a pixel window into MED and drives its partial bubble sort.
module med_ctrl
  import med_pkg::*;
#(
  parameter int N_PIXELS = 9
) (
  input  logic CLK,
  input  logic nRST,
  input  logic DSI,
  output logic MED_DSI,
  output logic BYP,
  output logic DSO,
  output logic BUSY,
  output logic ERR
);

  localparam int CW = cnt_width(N_PIXELS);
  localparam logic [CW-1:0] L_N        = CW'(N_PIXELS);
  localparam logic [CW-1:0] L_SAT      = CW'(N_PIXELS + 1);
  localparam logic [CW-1:0] L_IDX0     = CW'(N_PIXELS - 1);
  localparam logic [CW-1:0] L_IDX_LAST = CW'(last_idx(N_PIXELS));
  localparam logic [CW-1:0] L_FIN_LAST = CW'(final_len(N_PIXELS) - 1);
  localparam logic [CW-1:0] L_ONE      = CW'(1);

  med_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_idx;
  logic [CW-1:0] r_phase;
  logic          r_mdsi;
  logic          r_byp;
  logic          r_dso;
  logic          r_busy;
  logic          r_err;

  med_state_t    w_nxt_state;
  logic [CW-1:0] w_nxt_cnt;
  logic [CW-1:0] w_nxt_idx;
  logic [CW-1:0] w_nxt_phase;
  logic          w_nxt_err;
  logic          w_nxt_busy;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_phase <= '0;
      r_mdsi  <= 1'b0;
      r_byp   <= 1'b0;
      r_dso   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_idx   <= w_nxt_idx;
      r_phase <= w_nxt_phase;
      // Outputs for the sort phases come from the next state so they are glitch-free registers.
      r_mdsi  <= (w_nxt_state == ST_BYPS);
      r_byp   <= (w_nxt_state == ST_BYPS);
      r_dso   <= (w_nxt_state == ST_DONE);
      r_busy  <= w_nxt_busy;
      r_err   <= w_nxt_err;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_idx   = r_idx;
    w_nxt_phase = r_phase;
    w_nxt_err   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (DSI) begin
          w_nxt_state = ST_LOAD;
          w_nxt_cnt   = L_ONE;
        end
      end
      ST_LOAD: begin
        if (DSI) begin
          if (r_cnt != L_SAT) w_nxt_cnt = r_cnt + L_ONE;
        end else if (r_cnt == L_N) begin
          w_nxt_state = ST_CMP;
          w_nxt_cnt   = '0;
          w_nxt_idx   = L_IDX0;
          w_nxt_phase = '0;
        end else begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = '0;
          w_nxt_err   = 1'b1;
        end
      end
      ST_CMP: begin
        if (r_phase == r_idx - L_ONE) begin
          w_nxt_state = ST_BYPS;
          w_nxt_phase = '0;
        end else begin
          w_nxt_phase = r_phase + L_ONE;
        end
      end
      ST_BYPS: begin
        if (r_phase == L_N - r_idx - L_ONE) begin
          w_nxt_phase = '0;
          if (r_idx == L_IDX_LAST) begin
            w_nxt_state = ST_FINAL;
          end else begin
            w_nxt_state = ST_CMP;
            w_nxt_idx   = r_idx - L_ONE;
          end
        end else begin
          w_nxt_phase = r_phase + L_ONE;
        end
      end
      ST_FINAL: begin
        if (r_phase == L_FIN_LAST) begin
          w_nxt_state = ST_DONE;
          w_nxt_phase = '0;
        end else begin
          w_nxt_phase = r_phase + L_ONE;
        end
      end
      ST_DONE: begin
        w_nxt_state = ST_IDLE;
        w_nxt_idx   = '0;
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_cnt   = '0;
        w_nxt_idx   = '0;
        w_nxt_phase = '0;
      end
    endcase
  end

  assign w_nxt_busy = (w_nxt_state == ST_CMP) || (w_nxt_state == ST_BYPS) ||
                      (w_nxt_state == ST_FINAL) || (w_nxt_state == ST_DONE);

  // While loading, MED must see the upstream strobe in the same cycle it is presented.
  assign MED_DSI = ((r_state == ST_IDLE) || (r_state == ST_LOAD)) ? DSI : r_mdsi;
  assign BYP     = r_byp;
  assign DSO     = r_dso;
  assign BUSY    = r_busy;
  assign ERR     = r_err;

endmodule
